// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
//
// Built-in self-test harness for the 10-input/10-output combinational gate
// models. A 10-bit LFSR (x^10 + x^7 + 1) drives the model inputs, and a 10-bit
// MISR compacts the model responses over PATTERNS captures. The final signature
// is compared with a golden value to produce a single pass bit.
//
// Parameters:
//   PATTERNS  - patterns applied per run (1..65535)
//   SETTLE    - wait cycles between stimulus change and capture (0..15)
//   LFSR_SEED - LFSR start value (0 is replaced by 10'h001)
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - run request, honoured only in IDLE or DONE
//   stim      - stimulus, stim[0] drives N1 ... stim[9] drives N10
//   resp      - model response (combinational from stim)
//   golden    - expected signature, stable while busy
//   busy      - run in progress
//   done      - run complete, held until next start
//   pass      - signature matched (valid while done)
//   signature - current MISR contents
//   xerr      - sticky unknown-response flag
//
// Optional feature: define GATE_BIST_XCHECK_EN to flag X/Z bits on resp during
// every capture (simulation-only). Without it, xerr stays 0.
// -----------------------------------------------------------------------------
module gate_bist_ctrl #(
  parameter int unsigned PATTERNS  = 1023,
  parameter int unsigned SETTLE    = 0,
  parameter logic [9:0]  LFSR_SEED = 10'h001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [9:0] stim,
  input  logic [9:0] resp,
  input  logic [9:0] golden,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] signature,
  output logic       xerr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_COMPARE,
    S_DONE
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [9:0]  SEED       = (LFSR_SEED == 10'h000) ? 10'h001 : LFSR_SEED;
  localparam logic [15:0] PAT_LAST   = 16'(PATTERNS - 1);
  localparam int unsigned SET_LAST_I = (SETTLE == 0) ? 0 : SETTLE - 1;
  localparam logic [3:0]  SET_LAST   = SET_LAST_I[3:0];
  // State entered before each capture: skip SETTLE entirely when it is zero.
  localparam state_t      ENTRY      = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;

  state_t      r_state;
  logic [9:0]  r_lfsr;
  logic [9:0]  r_misr;
  logic [15:0] r_cnt;
  logic [3:0]  r_wcnt;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_xerr;

  logic [9:0]  w_lfsr_next;
  logic [9:0]  w_misr_next;

  assign w_lfsr_next = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
  assign w_misr_next = {r_misr[8:0], r_misr[9] ^ r_misr[6]} ^ resp;

  // NOTE: every register below is updated with non-blocking assignments so all
  // of them see the pre-edge values of each other, exactly like flip-flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_misr  <= 10'h000;
      r_cnt   <= 16'h0000;
      r_wcnt  <= 4'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_xerr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_lfsr  <= SEED;
            r_misr  <= 10'h000;
            r_cnt   <= 16'h0000;
            r_wcnt  <= 4'h0;
            r_pass  <= 1'b0;
            r_xerr  <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ENTRY;
          end
        end

        S_SETTLE: begin
          if (r_wcnt == SET_LAST) begin
            r_wcnt  <= 4'h0;
            r_state <= S_CAPTURE;
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end

        S_CAPTURE: begin
          // Response is sampled on the last edge of the stimulus hold; the next
          // stimulus appears on that same edge.
          r_misr <= w_misr_next;
          r_lfsr <= w_lfsr_next;
          r_cnt  <= r_cnt + 16'd1;
`ifdef GATE_BIST_XCHECK_EN
          if ($isunknown(resp)) begin
            r_xerr <= 1'b1;
          end
`endif
          if (r_cnt == PAT_LAST) begin
            r_state <= S_COMPARE;
          end else begin
            r_state <= ENTRY;
          end
        end

        S_COMPARE: begin
          // An X in the MISR makes the equality unknown; !r_xerr forces 0.
          r_pass  <= (r_misr == golden) && !r_xerr;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stim      = r_lfsr;
  assign signature = r_misr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign xerr      = r_xerr;

endmodule
